// File: rtl/ant_datapath_pkg.sv
// Shared constants and types for the ant datapath: field widths, opcodes,
// FSM state encoding and the decoded-instruction record.
package ant_datapath_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH    = 16;
    localparam int MEM_DATA_WIDTH    = 16;
    localparam int RESULT_WIDTH      = 16;
    localparam int STORE_DATA_WIDTH  = 12;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_DRAW  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;

    localparam logic [2:0] ANT_COLOUR = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_LOAD_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        KIND_NOP,
        KIND_DRAW,
        KIND_LOAD,
        KIND_STORE,
        KIND_ILLEGAL
    } op_kind_t;

    typedef struct packed {
        op_kind_t                        kind;
        logic [MEM_ADDR_WIDTH-1:0]       addr;
        logic [STORE_DATA_WIDTH-1:0]     storeData;
        logic                            plot;
        logic [2:0]                      colour;
        logic [6:0]                      y;
        logic [7:0]                      x;
    } decoded_t;

    // Opcodes 4..15 are undefined and collapse into a single illegal kind.
    function automatic op_kind_t classify(input logic [3:0] opcode);
        op_kind_t kind;
        case (opcode)
            OP_NOP:   kind = KIND_NOP;
            OP_DRAW:  kind = KIND_DRAW;
            OP_LOAD:  kind = KIND_LOAD;
            OP_STORE: kind = KIND_STORE;
            default:  kind = KIND_ILLEGAL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/ant_datapath_instr_decode.sv
// Purely combinational split of a raw instruction word into its fields.
// Every field is extracted unconditionally; the consumer picks by kind.
module instr_decode
    import ant_datapath_pkg::*;
(
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_i,
    output decoded_t                     decoded_o
);

    // Reserved operand bits are deliberately never inspected.
    always_comb begin
        decoded_o.kind      = classify(instruction_i[31:28]);
        decoded_o.addr      = instruction_i[15:0];
        decoded_o.storeData = instruction_i[27:16];
        decoded_o.plot      = instruction_i[18];
        decoded_o.colour    = instruction_i[17:15];
        decoded_o.y         = instruction_i[14:8];
        decoded_o.x         = instruction_i[7:0];
    end

endmodule

// File: rtl/ant_datapath.sv
// Ant datapath: executes one NOP/DRAW/LOAD/STORE instruction per start request
// and reports completion with a one-cycle finished pulse.
module ant_datapath
    import ant_datapath_pkg::*;
#(
    parameter int MEM_READ_LATENCY = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start_dp,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
    output logic                         finished_dp,
    output logic [RESULT_WIDTH-1:0]      result_dp,
    output logic                         illegal_op,
    output logic                         busy,
    output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
    output logic [MEM_DATA_WIDTH-1:0]    mem_data,
    output logic                         mem_wren,
    input  logic [MEM_DATA_WIDTH-1:0]    mem_q,
    output logic [7:0]                   vga_x,
    output logic [6:0]                   vga_y,
    output logic [2:0]                   vga_colour,
    output logic                         vga_plot
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_READ_LATENCY - 1);

    decoded_t decoded;

    state_t                       state_q;
    op_kind_t                     kind_q;
    logic [2:0]                   waitCount_q;
    logic                         finished_q;
    logic                         illegal_q;
    logic                         busy_q;
    logic [RESULT_WIDTH-1:0]      result_q;
    logic [MEM_ADDR_WIDTH-1:0]    memAddress_q;
    logic [MEM_DATA_WIDTH-1:0]    memData_q;
    logic                         memWren_q;
    logic [7:0]                   vgaX_q;
    logic [6:0]                   vgaY_q;
    logic [2:0]                   vgaColour_q;
    logic                         vgaPlot_q;

    instr_decode u_decode (
        .instruction_i (instruction_dp),
        .decoded_o     (decoded)
    );

    // Outputs are registered on the accepting edge so memory and VGA see
    // them throughout cycle 1; strobes default low so they last one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            kind_q       <= KIND_NOP;
            waitCount_q  <= '0;
            finished_q   <= 1'b0;
            illegal_q    <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
            memAddress_q <= '0;
            memData_q    <= '0;
            memWren_q    <= 1'b0;
            vgaX_q       <= '0;
            vgaY_q       <= '0;
            vgaColour_q  <= '0;
            vgaPlot_q    <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            illegal_q  <= 1'b0;
            memWren_q  <= 1'b0;
            vgaPlot_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_dp) begin
                        state_q <= ST_EXEC;
                        busy_q  <= 1'b1;
                        kind_q  <= decoded.kind;
                        case (decoded.kind)
                            KIND_DRAW: begin
                                vgaX_q      <= decoded.x;
                                vgaY_q      <= decoded.y;
                                vgaColour_q <= decoded.colour;
                                vgaPlot_q   <= decoded.plot;
                            end
                            KIND_LOAD: begin
                                memAddress_q <= decoded.addr;
                            end
                            KIND_STORE: begin
                                memAddress_q <= decoded.addr;
                                memData_q    <= {{(MEM_DATA_WIDTH-STORE_DATA_WIDTH){1'b0}},
                                                 decoded.storeData};
                                memWren_q    <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (kind_q == KIND_LOAD) begin
                        state_q     <= ST_LOAD_WAIT;
                        waitCount_q <= WAIT_LAST;
                    end else begin
                        state_q    <= ST_DONE;
                        finished_q <= 1'b1;
                        illegal_q  <= (kind_q == KIND_ILLEGAL);
                    end
                end
                // mem_q becomes valid in the last wait cycle, so capture there.
                ST_LOAD_WAIT: begin
                    if (waitCount_q == 3'd0) begin
                        result_q   <= mem_q;
                        state_q    <= ST_DONE;
                        finished_q <= 1'b1;
                    end else begin
                        waitCount_q <= waitCount_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign finished_dp = finished_q;
    assign illegal_op  = illegal_q;
    assign busy        = busy_q;
    assign result_dp   = result_q;
    assign mem_address = memAddress_q;
    assign mem_data    = memData_q;
    assign mem_wren    = memWren_q;
    assign vga_x       = vgaX_q;
    assign vga_y       = vgaY_q;
    assign vga_colour  = vgaColour_q;
    assign vga_plot    = vgaPlot_q;

endmodule
